// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer and edge/long-press/toggle generator for active-low push buttons.
// Every key channel is fully independent; all outputs are registered.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// IDLE      | released and stable
// PRESS_CHK | synchronised input went low, counting stable low samples
// DOWN      | pressed and stable, hold counter running
// REL_CHK   | synchronised input went high, counting stable high samples
module key_conditioner #(
  parameter int NUM_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_toggle
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    DOWN      = 2'd2,
    REL_CHK   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic             sync1_q, sync2_q;
    state_e           state_q;
    logic [CNT_W-1:0] dcnt_q, hcnt_q;
    logic             level_q, press_q, rel_q, long_q, tog_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        // synchroniser resets to "released" so a held key is seen as a fresh press
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        state_q <= IDLE;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        tog_q   <= 1'b0;
      end else begin
        sync1_q <= key_n[i];
        sync2_q <= sync1_q;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        case (state_q)
          IDLE: begin
            if (!sync2_q) begin
              state_q <= PRESS_CHK;
              dcnt_q  <= '0;
            end
          end
          PRESS_CHK: begin
            if (sync2_q) begin
              state_q <= IDLE;
            end else if (dcnt_q == DB_LAST) begin
              state_q <= DOWN;
              press_q <= 1'b1;
              level_q <= 1'b1;
              tog_q   <= ~tog_q;
              hcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + ONE;
            end
          end
          DOWN: begin
            if (sync2_q) begin
              state_q <= REL_CHK;
              dcnt_q  <= '0;
            end else if (hcnt_q != LP_MAX) begin
              // saturation at LP_MAX keeps key_long to one pulse per press
              hcnt_q <= hcnt_q + ONE;
              long_q <= (hcnt_q == LP_LAST);
            end
          end
          REL_CHK: begin
            if (!sync2_q) begin
              state_q <= DOWN;
            end else if (dcnt_q == DB_LAST) begin
              state_q <= IDLE;
              rel_q   <= 1'b1;
              level_q <= 1'b0;
            end else begin
              dcnt_q <= dcnt_q + ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = rel_q;
    assign key_long[i]    = long_q;
    assign key_toggle[i]  = tog_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random bouncing keys, checked every
// cycle against a run-length model of the debounce and hold behaviour.
module tb_key_conditioner;
  localparam int NK = 3;
  localparam int DB = 4;
  localparam int LP = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level, key_press, key_release, key_long, key_toggle;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_toggle(key_toggle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a level flips once the synchronised input has disagreed with it for
  // DB+1 consecutive samples; hold time counts stable-pressed samples only.
  logic [NK-1:0] m_s0, m_s1, m_lvl, m_tog, m_press, m_rel, m_long;
  int m_run[NK];
  int m_hold[NK];

  always @(posedge clk) begin
    if (reset) begin
      m_s0 = '1; m_s1 = '1; m_lvl = '0; m_tog = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end
    end else begin
      m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < NK; k++) begin
        logic pressed_now, opp;
        pressed_now = ~m_s1[k];
        opp = (pressed_now != m_lvl[k]);
        if (m_lvl[k] && pressed_now && m_run[k] == 0) begin
          if (m_hold[k] == LP - 1) m_long[k] = 1'b1;
          if (m_hold[k] < LP) m_hold[k]++;
        end
        if (opp) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_run[k] = 0;
            m_lvl[k] = pressed_now;
            if (pressed_now) begin
              m_press[k] = 1'b1;
              m_tog[k]   = ~m_tog[k];
              m_hold[k]  = 0;
            end else begin
              m_rel[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s1 = m_s0;
      m_s0 = key_n;
    end
  end

  int press_cnt[NK];
  int rel_cnt[NK];
  int long_cnt[NK];

  task automatic clr_cnt();
    for (int k = 0; k < NK; k++) begin press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0; end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("level",   32'(key_level),   32'(m_lvl));
    chk("press",   32'(key_press),   32'(m_press));
    chk("release", 32'(key_release), 32'(m_rel));
    chk("long",    32'(key_long),    32'(m_long));
    chk("toggle",  32'(key_toggle),  32'(m_tog));
    for (int k = 0; k < NK; k++) begin
      if (key_press[k])   press_cnt[k]++;
      if (key_release[k]) rel_cnt[k]++;
      if (key_long[k])    long_cnt[k]++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int lat, t_press, t_long;
  int rem[NK];

  initial begin
    reset = 1'b1;
    key_n = '1;
    repeat (3) tick();
    chk("rst_outputs", 32'({key_level, key_press, key_release, key_long, key_toggle}), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // clean press: press visible at the 7th sample after driving (edge k+6)
    clr_cnt();
    key_n[0] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (key_press[0]) lat = i;
    end
    chk("clean_press_lat", 32'(lat), 32'd7);
    chk("clean_level", 32'(key_level), 32'b001);
    chk("clean_toggle", 32'(key_toggle), 32'b001);
    tick();
    chk("clean_pulse_one_cycle", 32'(key_press[0]), 32'd0);
    repeat (3) tick();
    key_n[0] = 1'b1;
    repeat (12) tick();

    // bounce rejection on key 1
    clr_cnt();
    for (int b = 0; b < 4; b++) begin
      key_n[1] = b[0];
      repeat (2) tick();
    end
    chk("bounce_no_press", 32'(press_cnt[1]), 32'd0);
    chk("bounce_level", 32'(key_level[1]), 32'd0);
    key_n[1] = 1'b0;
    repeat (12) tick();
    chk("bounce_then_press", 32'(press_cnt[1]), 32'd1);
    key_n[1] = 1'b1;
    repeat (12) tick();

    // long press on key 2
    clr_cnt();
    t_press = -1; t_long = -1;
    key_n[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (key_press[2]) t_press = i;
      if (key_long[2])  t_long  = i;
    end
    chk("long_offset", 32'(t_long - t_press), 32'd10);
    chk("long_once", 32'(long_cnt[2]), 32'd1);
    key_n[2] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (key_release[2]) lat = i;
    end
    chk("long_release_lat", 32'(lat), 32'd7);
    repeat (3) tick();

    // toggle sequence on key 0 from a fresh reset
    do_reset();
    clr_cnt();
    for (int p = 0; p < 3; p++) begin
      key_n[0] = 1'b0;
      repeat (9) tick();
      key_n[0] = 1'b1;
      repeat (9) tick();
    end
    chk("toggle_press_cnt", 32'(press_cnt[0]), 32'd3);
    chk("toggle_rel_cnt", 32'(rel_cnt[0]), 32'd3);
    chk("toggle_final", 32'(key_toggle[0]), 32'd1);

    // reset mid-debounce (dcnt = 2) with key still held
    do_reset();
    clr_cnt();
    key_n[0] = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midrst_outputs", 32'({key_level, key_press, key_release, key_long, key_toggle}), 32'd0);
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (key_press[0]) lat = i;
    end
    chk("midrst_press_lat", 32'(lat), 32'd7);
    chk("midrst_press_cnt", 32'(press_cnt[0]), 32'd1);
    key_n = '1;
    repeat (12) tick();

    // simultaneous press on all keys
    do_reset();
    key_n = '0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (key_press != '0) lat = i;
    end
    chk("simul_press", 32'(key_press), 32'b111);
    chk("simul_toggle", 32'(key_toggle), 32'b111);
    key_n = '1;
    repeat (12) tick();

    // random bouncing keys with occasional reset
    for (int k = 0; k < NK; k++) rem[k] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = 1'($urandom_range(0, 1));
          rem[k]   = (($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25))
                                                  : int'($urandom_range(1, 7)));
        end
        rem[k]--;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
